// File: rtl/npu_layer_sequencer_if.sv
// RAM and MAC-engine signals between the layer sequencer (master) and the
// memory / systolic MAC side (slave).
interface npu_layer_sequencer_if #(
  parameter int N  = 10,
  parameter int W  = 16,
  parameter int AW = 10
);
  logic [AW-1:0]      ram_addr;
  logic               ram_re;
  logic [W-1:0]       ram_rdata;
  logic               ram_we;
  logic [W-1:0]       ram_wdata;
  logic               mac_start;
  logic [N*N*W-1:0]   mac_a_flat;
  logic               mac_done;
  logic [N*N*W-1:0]   mac_r_flat;

  modport master (
    output ram_addr, ram_re, ram_we, ram_wdata, mac_start, mac_a_flat,
    input  ram_rdata, mac_done, mac_r_flat
  );

  modport slave (
    input  ram_addr, ram_re, ram_we, ram_wdata, mac_start, mac_a_flat,
    output ram_rdata, mac_done, mac_r_flat
  );
endinterface

// File: rtl/npu_layer_sequencer.sv
// Layer sequencer: loads an NxN matrix from RAM, runs the MAC engine, then
// writes the result back through leaky-ReLU / rounding-shift normalisation.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for start; job parameters latched on acceptance
// S_LOAD      | N*N reads from src_base, plus one cycle for the last capture
// S_MAC_START | one-cycle mac_start pulse
// S_MAC_WAIT  | waiting for mac_done, bounded by MAC_TIMEOUT cycles
// S_STORE     | N*N writes of f(buffer[k]) to dst_base
// S_DONE      | one-cycle done pulse (err set on timeout)
module npu_layer_sequencer #(
  parameter int N           = 10,
  parameter int W           = 16,
  parameter int AW          = 10,
  parameter int LEAK_SHIFT  = 3,
  parameter int MAC_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [AW-1:0]          src_base_i,
  input  logic [AW-1:0]          dst_base_i,
  input  logic [1:0]             mode_i,
  input  logic [3:0]             norm_shift_i,
  npu_layer_sequencer_if.master  bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);
  localparam int NE = N * N;
  localparam int CW = $clog2(NE + 1);
  localparam int TW = $clog2(MAC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC_START, S_MAC_WAIT, S_STORE, S_DONE
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [TW-1:0]  tmr_q;
  logic [AW-1:0]  src_q;
  logic [AW-1:0]  dst_q;
  logic [1:0]     mode_q;
  logic [3:0]     shift_q;
  logic [NE*W-1:0] buf_q;
  logic [AW-1:0]  ram_addr_q;
  logic           ram_re_q;
  logic           ram_we_q;
  logic [W-1:0]   ram_wdata_q;
  logic           mac_start_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;

  int             ld_idx;
  int             st_idx;
  logic [W-1:0]   st_elem_d;
  logic [W-1:0]   st_wdata_d;

  function automatic logic [W-1:0] elem_fn(input logic [W-1:0] x,
                                           input logic [1:0] mode,
                                           input logic [3:0] sh);
    logic signed [W-1:0] a;
    logic signed [W:0]   sum;
    a = signed'(x);
    if (mode[0] && a < 0) a = a >>> LEAK_SHIFT;
    if (mode[1] && sh != 4'd0) begin
      // One extra bit of headroom keeps the rounding add from overflowing.
      sum = {a[W-1], a} + ((W+1)'(1) << (sh - 4'd1));
      sum = sum >>> sh;
      return sum[W-1:0];
    end
    return a;
  endfunction

  always_comb begin
    ld_idx = int'(cnt_q) - 1;
    st_idx = (cnt_q == CW'(NE - 1)) ? 0 : int'(cnt_q) + 1;
    // Entering STORE, buffer[0] is being overwritten by the MAC result this edge.
    st_elem_d = (state_q == S_MAC_WAIT) ? bus.mac_r_flat[W-1:0]
                                        : buf_q[st_idx*W +: W];
    st_wdata_d = elem_fn(st_elem_d, mode_q, shift_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmr_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      mode_q      <= '0;
      shift_q     <= '0;
      buf_q       <= '0;
      ram_addr_q  <= '0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      mac_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      mac_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_LOAD;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            src_q      <= src_base_i;
            dst_q      <= dst_base_i;
            mode_q     <= mode_i;
            shift_q    <= norm_shift_i;
            cnt_q      <= '0;
            ram_re_q   <= 1'b1;
            ram_addr_q <= src_base_i;
          end
        end
        S_LOAD: begin
          if (cnt_q != '0) buf_q[ld_idx*W +: W] <= bus.ram_rdata;
          if (cnt_q == CW'(NE)) begin
            state_q     <= S_MAC_START;
            mac_start_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(NE - 1)) begin
              ram_re_q   <= 1'b0;
              ram_addr_q <= '0;
            end else begin
              ram_addr_q <= src_q + AW'(cnt_q) + AW'(1);
            end
          end
        end
        S_MAC_START: begin
          state_q <= S_MAC_WAIT;
          tmr_q   <= TW'(MAC_TIMEOUT - 1);
        end
        S_MAC_WAIT: begin
          if (bus.mac_done) begin
            buf_q       <= bus.mac_r_flat;
            state_q     <= S_STORE;
            cnt_q       <= '0;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= dst_q;
            ram_wdata_q <= st_wdata_d;
          end else if (tmr_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_STORE: begin
          if (cnt_q == CW'(NE - 1)) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
          end else begin
            cnt_q       <= cnt_q + 1'b1;
            ram_addr_q  <= dst_q + AW'(cnt_q) + AW'(1);
            ram_wdata_q <= st_wdata_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_re     = ram_re_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.mac_start  = mac_start_q;
  assign bus.mac_a_flat = buf_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_npu_layer_sequencer.sv
// Scoreboard bench for npu_layer_sequencer with N=2: RAM and MAC models,
// directed jobs push expected reads/writes/done events, a monitor pops them.
module tb_npu_layer_sequencer;
  localparam int N = 2, W = 16, AW = 10, NE = 4, TMO = 16;

  typedef logic [W-1:0] vec_t [NE];
  typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
  typedef struct { int cyc; logic err; } dn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start;
  logic [AW-1:0] src_base, dst_base;
  logic [1:0] mode;
  logic [3:0] norm_shift;
  logic busy, done, err;
  logic mac_en;
  logic [NE*W-1:0] mac_res;

  npu_layer_sequencer_if #(.N(N), .W(W), .AW(AW)) bus ();

  npu_layer_sequencer #(.N(N), .W(W), .AW(AW), .LEAK_SHIFT(3), .MAC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start), .src_base_i(src_base), .dst_base_i(dst_base),
    .mode_i(mode), .norm_shift_i(norm_shift), .bus(bus),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [W-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  always @(posedge clk) bus.mac_done <= mac_en && bus.mac_start;
  assign bus.mac_r_flat = mac_res;

  wr_t             wr_q[$];
  logic [AW-1:0]   rd_q[$];
  logic [NE*W-1:0] mac_q[$];
  dn_t             done_q[$];
  int n_vec = 0, n_err = 0, overlap = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event with value %0h, required none", nm, act);
  endtask

  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    logic [AW-1:0] ra;
    if (!rst) begin
      if (bus.ram_re && bus.ram_we) overlap++;
      if (bus.ram_re) begin
        if (rd_q.size() == 0) unexpected("unexpected_read", bus.ram_addr);
        else begin ra = rd_q.pop_front(); chk("rd_addr", bus.ram_addr, ra); end
      end
      if (bus.ram_we) begin
        if (wr_q.size() == 0) unexpected("unexpected_write", bus.ram_addr);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", bus.ram_addr, w.addr);
          chk("wr_data", bus.ram_wdata, w.data);
        end
      end
      if (bus.mac_start) begin
        if (mac_q.size() == 0) unexpected("unexpected_mac_start", bus.mac_a_flat);
        else chk("mac_a_flat", bus.mac_a_flat, mac_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) unexpected("unexpected_done", err);
        else begin
          d = done_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_err", err, d.err);
        end
      end
    end
  end

  task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [1:0] md, input logic [3:0] sh,
                         input vec_t a, input vec_t r, input vec_t e,
                         input bit tmo, input bit noisy, input bit abort);
    logic [AW-1:0] ad;
    logic [NE*W-1:0] exp_a;
    wr_t w;
    dn_t d;
    int e0, d0;
    bit seen;
    for (int k = 0; k < NE; k++) begin
      ad = src + AW'(k);
      mem[ad] = a[k];
      rd_q.push_back(ad);
      exp_a[k*W +: W] = a[k];
      mac_res[k*W +: W] = r[k];
    end
    for (int k = 0; k < NE; k++) begin
      ad = dst + AW'(k);
      mem[ad] = 16'h5a5a;
      if (!tmo) begin w.addr = ad; w.data = e[k]; wr_q.push_back(w); end
    end
    mac_q.push_back(exp_a);
    mac_en = !tmo;
    d0 = done_cnt;
    @(negedge clk);
    e0 = cyc + 1;
    d.cyc = tmo ? e0 + NE + 2 + TMO : e0 + 2*NE + 3;
    d.err = tmo;
    done_q.push_back(d);
    src_base = src; dst_base = dst; mode = md; norm_shift = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_base = ~src; dst_base = ~dst; mode = ~md; norm_shift = ~sh;
    chk("busy_after_start", busy, 1'b1);
    chk("err_cleared_on_start", err, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      start = noisy && (cyc == e0 + 2 || cyc == e0 + 7);
      if (abort && cyc == e0 + 7) begin
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_outputs", {busy, done, err, bus.ram_we, bus.ram_re, bus.mac_start}, 6'b0);
        chk("abort_mac_a_flat", bus.mac_a_flat, '0);
        chk("abort_writes_left", wr_q.size(), NE - 1);
        chk("abort_mem_first", mem[dst], e[0]);
        chk("abort_mem_second", mem[AW'(dst + AW'(1))], 16'h5a5a);
        wr_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        return;
      end
      @(negedge clk);
      #1;
      if (done_cnt != d0) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", done_cnt, d0 + 1);
    @(negedge clk);
    #1;
    chk("busy_after_done", busy, 1'b0);
    chk("err_after_done", err, tmo);
    for (int k = 0; k < NE; k++)
      chk("mem_result", mem[AW'(dst + AW'(k))], tmo ? 16'h5a5a : e[k]);
    chk("queues_drained", wr_q.size() + rd_q.size() + mac_q.size() + done_q.size(), 0);
  endtask

  vec_t va, vr, vz;

  initial begin
    start = 1'b0; src_base = '0; dst_base = '0; mode = '0; norm_shift = '0;
    mac_en = 1'b0; mac_res = '0;
    va = '{16'd1, 16'd2, 16'd3, 16'd4};
    vr = '{16'd100, -16'sd80, 16'd7, -16'sd1};
    vz = '{16'd0, 16'd0, 16'd0, 16'd0};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, err, bus.ram_we, bus.ram_re, bus.mac_start}, 6'b0);
    chk("reset_ram_addr", bus.ram_addr, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {busy, done, err, bus.ram_we, bus.ram_re, bus.mac_start}, 6'b0);
    chk("idle_mac_a_flat", bus.mac_a_flat, '0);

    run_job(0, 100, 2'b00, 4'd0, va, vr, vr, 0, 0, 0);
    run_job(0, 100, 2'b01, 4'd0, va, vr, '{16'd100, -16'sd10, 16'd7, -16'sd1}, 0, 0, 0);
    run_job(0, 100, 2'b10, 4'd2, va, vr, '{16'd25, -16'sd20, 16'd2, 16'd0}, 0, 0, 0);
    run_job(0, 100, 2'b10, 4'd2, va, '{16'd32767, 16'h8000, 16'd5, 16'd6},
            '{16'd8192, -16'sd8192, 16'd1, 16'd2}, 0, 0, 0);
    run_job(0, 100, 2'b11, 4'd1, va, '{-16'sd80, 16'd9, -16'sd1, 16'd3},
            '{-16'sd5, 16'd5, 16'd0, 16'd2}, 0, 0, 0);
    run_job(0, 100, 2'b10, 4'd0, va, vr, vr, 0, 0, 0);
    run_job(1022, 200, 2'b00, 4'd0, '{16'd11, 16'd12, 16'd13, 16'd14}, vr, vr, 0, 0, 0);
    run_job(10, 1022, 2'b01, 4'd0, va, vr, '{16'd100, -16'sd10, 16'd7, -16'sd1}, 0, 0, 0);
    run_job(0, 100, 2'b00, 4'd0, va, vr, vz, 1, 0, 0);
    run_job(0, 100, 2'b00, 4'd0, va, vr, vr, 0, 0, 0);
    run_job(0, 100, 2'b00, 4'd0, va, vr, vr, 0, 1, 0);
    run_job(0, 100, 2'b00, 4'd0, va, vr, vr, 0, 0, 1);
    run_job(0, 100, 2'b01, 4'd0, va, vr, '{16'd100, -16'sd10, 16'd7, -16'sd1}, 0, 0, 0);

    chk("re_we_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule

// File: doc/npu_layer_sequencer.md
# npu_layer_sequencer

Parametrised layer sequencer for the NPU datapath. On a start pulse it loads an N×N signed matrix from synchronous RAM into an internal buffer and hands it to the external systolic MAC engine with a start/done handshake. It then streams the MAC result back to RAM at a destination base, applying an optional leaky-ReLU and rounding-shift normalisation per element. It generalises the fixed 10×10 top-level flow to any N, W and address width, adds activation and normalisation modes, and adds a MAC timeout.

## Interface
- N, 10, matrix dimension (N×N elements, row-major)
- W, 16, signed element width
- AW, 10, RAM address width
- LEAK_SHIFT, 3, leaky-ReLU slope = 2^-LEAK_SHIFT
- MAC_TIMEOUT, 1024, maximum cycles spent in MAC_WAIT

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  job request; sampled only in IDLE
- src_base, dst_base  in  AW  RAM base addresses; latched at start
- mode  in  2  bit0 = leaky-ReLU enable, bit1 = normalise enable; latched at start
- norm_shift  in  4  normalisation shift amount; latched at start
- ram_addr  out  AW  RAM address
- ram_re  out  1  read enable; data is returned one cycle later
- ram_rdata  in  W  read data
- ram_we  out  1  write enable
- ram_wdata  out  W  write data
- mac_start  out  1  one-cycle pulse to the MAC engine
- mac_a_flat  out  N*N*W  buffered matrix; element (i,j) at [(i*N+j)*W +: W]
- mac_done  in  1  MAC result valid (level)
- mac_r_flat  in  N*N*W  MAC result, same packing as mac_a_flat
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  timeout flag; set with done, cleared at the next accepted start

## Operation
- States and transitions:
  - IDLE → LOAD when start=1.
  - LOAD → MAC_START after N*N+1 cycles.
  - MAC_START → MAC_WAIT after 1 cycle.
  - MAC_WAIT → STORE when mac_done=1.
  - MAC_WAIT → DONE with err=1 after MAC_TIMEOUT cycles without mac_done.
  - STORE → DONE after N*N cycles.
  - DONE → IDLE after 1 cycle.
- LOAD:
  - Cycle k (0..N*N-1): ram_re=1, ram_addr=src_base+k.
  - ram_rdata in cycle k+1 is written to buffer[k].
  - Cycle N*N issues no read and only captures the last element.
- MAC_START: mac_start=1. mac_a_flat continuously reflects the buffer.
- MAC_WAIT: in the cycle mac_done=1, mac_r_flat is latched into the buffer, overwriting the input.
- STORE:
  - Cycle k: ram_we=1, ram_addr=dst_base+k, ram_wdata=f(buffer[k]).
- Element function f, evaluated combinationally:
  - a = (mode[0] && x<0) ? x >>> LEAK_SHIFT : x. Arithmetic shift, so results floor toward −∞.
  - If mode[1] and s=norm_shift>0: y = (a + 2^(s-1)) >>> s, computed in W+1 bits then truncated to W. No overflow is possible.
  - Otherwise y = a.
- Addresses wrap modulo 2^AW.
- start while busy is ignored. Base, mode and norm_shift changes after acceptance have no effect on the running job.
- A timeout produces no RAM writes. A mac_done arriving later, while IDLE, is ignored.

## Timing
- Reset values: all outputs 0, buffer cleared to 0, state IDLE, counters 0.
- rst mid-job aborts immediately:
  - No further RAM accesses.
  - No done pulse.
  - Partial destination writes are left in place.
- start is sampled at edge e0; LOAD occupies the cycles after edges e0..e(N*N).
- If mac_done is high in the first MAC_WAIT cycle, done is high in the cycle after edge e(2*N*N+3). Each extra MAC_WAIT cycle adds one.
- On timeout, done=err=1 occurs in the cycle after MAC_WAIT has lasted MAC_TIMEOUT cycles.
- ram_re and ram_we are never high in the same cycle.
- mac_start is high for exactly one cycle per job.

## Test plan
All scenarios use N=2, W=16, LEAK_SHIFT=3 and a RAM model with 1-cycle read latency.
- Bypass: RAM[0..3]={1,2,3,4}, src_base=0, dst_base=100, mode=00; MAC model returns {100,-80,7,-1} one cycle after mac_start.
  - mac_a_flat={1,2,3,4}.
  - RAM[100..103]={100,-80,7,-1}.
  - done is high in the cycle after e11; busy is low afterwards.
- Leaky, mode=01, same MAC result → RAM[100..103]={100,-10,7,-1}.
- Normalise, mode=10, norm_shift=2:
  - Result {100,-80,7,-1} → {25,-20,2,0}.
  - Result {32767,…} → 8192 for that element.
- Timeout: MAC_TIMEOUT=16, mac_done held 0 → done=1 and err=1 together, with zero ram_we cycles. The next start clears err.
- start pulsed during LOAD and STORE → ignored; exactly one done pulse and 4 writes.
- rst asserted in the second STORE cycle:
  - All outputs are 0 immediately.
  - Only RAM[100] has been written.
  - A new start afterwards completes normally.
